// File: rtl/rv32i_types.sv
// Shared core types: the common-data-bus broadcast record and its requester indices.
package rv32i_types;

   localparam int unsigned CDB_NUM_REQ = 3;
   localparam int unsigned CDB_TAG_W   = 3;
   localparam int unsigned CDB_WIDTH   = 32;
   localparam int unsigned CDB_SRC_W   = $clog2(CDB_NUM_REQ);

   localparam int unsigned CDB_ALU = 0;
   localparam int unsigned CDB_BR  = 1;
   localparam int unsigned CDB_LSQ = 2;

   typedef struct packed {
      logic                 valid;
      logic [CDB_TAG_W-1:0] tag;
      logic [CDB_WIDTH-1:0] data;
      logic [CDB_SRC_W-1:0] src;
   } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority select: first asserted request at or after ptr, with wrap.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SRC_W-1:0]   idx
);

   logic        found;
   int unsigned k;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         // Explicit modulo so non-power-of-two requester counts wrap correctly.
         k = int'(ptr) + i;
         if (k >= NUM_REQ) k = k - NUM_REQ;
         if (en && !found && req[k]) begin
            gnt[k] = 1'b1;
            idx    = SRC_W'(k);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants one ready producer per cycle onto a registered broadcast,
// honouring ROB back-pressure (cdb_stall) and mispredict flush.
module cdb_arbiter
   import rv32i_types::*;
#(
   parameter int unsigned NUM_REQ = CDB_NUM_REQ,
   parameter int unsigned TAG_W   = CDB_TAG_W,
   parameter int unsigned WIDTH   = CDB_WIDTH,
   parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     flush,
   input  logic                     cdb_stall,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [WIDTH-1:0]         cdb_data,
   output logic [SRC_W-1:0]         cdb_src
);

   logic             valid_q, valid_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SRC_W-1:0] src_q, src_d;
   logic [SRC_W-1:0] ptr_q, ptr_d;

   logic             reg_free;
   logic             arb_en;
   logic             grant;
   logic [SRC_W-1:0] win_idx;

   assign reg_free = !valid_q || !cdb_stall;
   assign arb_en   = rst && !flush && reg_free;
   assign grant    = |req_ready;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ),
      .SRC_W  (SRC_W)
   ) u_rr (
      .req(req_valid),
      .ptr(ptr_q),
      .en (arb_en),
      .gnt(req_ready),
      .idx(win_idx)
   );

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      src_d   = src_q;
      ptr_d   = ptr_q;
      // Flush takes priority over both stall-hold and a fresh grant.
      if (flush) begin
         valid_d = 1'b0;
      end else if (reg_free) begin
         if (grant) begin
            valid_d = 1'b1;
            tag_d   = req_tag[win_idx*TAG_W +: TAG_W];
            data_d  = req_data[win_idx*WIDTH +: WIDTH];
            src_d   = win_idx;
            ptr_d   = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
      end
   end

   assign cdb_valid = valid_q;
   assign cdb_tag   = tag_q;
   assign cdb_data  = data_q;
   assign cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, contention, wrap, stall, flush, idle, reset-mid-stall.
module tb_cdb_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [8:0]  req_tag;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        flush;
   logic        cdb_stall;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [1:0]  cdb_src;

   int passed = 0;
   int total  = 0;

   cdb_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_tag  (req_tag),
      .req_data (req_data),
      .req_ready(req_ready),
      .flush    (flush),
      .cdb_stall(cdb_stall),
      .cdb_valid(cdb_valid),
      .cdb_tag  (cdb_tag),
      .cdb_data (cdb_data),
      .cdb_src  (cdb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge, then let comb settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] t, input logic [31:0] d);
      req_tag[i*3 +: 3]   = t;
      req_data[i*32 +: 32] = d;
   endtask

   initial begin
      int unsigned g_seq [5];
      logic [2:0]  tag_of [3];
      g_seq  = '{0, 1, 2, 0, 1};
      tag_of = '{3'd1, 3'd2, 3'd3};

      rst = 1'b0; flush = 1'b0; cdb_stall = 1'b0;
      req_valid = 3'b111; req_tag = '0; req_data = '0;
      set_req(0, 3'd1, 32'h100);
      set_req(1, 3'd2, 32'h200);
      set_req(2, 3'd3, 32'h300);

      // Reset held with all requesters valid
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_ready", 32'(req_ready), 32'h0);
         chk("rst_valid", 32'(cdb_valid), 32'h0);
      end
      chk("rst_tag", 32'(cdb_tag), 32'h0);
      chk("rst_data", cdb_data, 32'h0);

      // Release: full contention grants 0,1,2,0,1
      rst = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("cont_ready%0d", i), 32'(req_ready), 32'(1 << g_seq[i]));
         tick();
         chk($sformatf("cont_valid%0d", i), 32'(cdb_valid), 32'h1);
         chk($sformatf("cont_src%0d", i), 32'(cdb_src), 32'(g_seq[i]));
         chk($sformatf("cont_tag%0d", i), 32'(cdb_tag), 32'(tag_of[g_seq[i]]));
      end
      chk("cont_data", cdb_data, 32'h200);

      // Only req2: first grant wraps ptr 2->0, then a grant from ptr 0 lands on req2 again
      req_valid = 3'b100;
      #1;
      chk("wrap_pre_ready", 32'(req_ready), 32'h4);
      tick();
      chk("wrap_pre_ptr", 32'(dut.ptr_q), 32'h0);
      set_req(2, 3'd6, 32'h1234);
      #1;
      chk("wrap_ready", 32'(req_ready), 32'h4);
      tick();
      chk("wrap_tag", 32'(cdb_tag), 32'h6);
      chk("wrap_data", cdb_data, 32'h1234);
      chk("wrap_src", 32'(cdb_src), 32'h2);
      chk("wrap_ptr", 32'(dut.ptr_q), 32'h0);

      // Stall: put tag 5 / DEADBEEF on the bus, then hold it for 3 cycles
      req_valid = 3'b001;
      set_req(0, 3'd5, 32'hDEADBEEF);
      #1;
      chk("stall_load_ready", 32'(req_ready), 32'h1);
      tick();
      chk("stall_load_tag", 32'(cdb_tag), 32'h5);
      set_req(0, 3'd7, 32'h55);
      cdb_stall = 1'b1;
      #1;
      chk("stall_ready0", 32'(req_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("stall_valid%0d", i), 32'(cdb_valid), 32'h1);
         chk($sformatf("stall_tag%0d", i), 32'(cdb_tag), 32'h5);
         chk($sformatf("stall_data%0d", i), cdb_data, 32'hDEADBEEF);
         chk($sformatf("stall_ready%0d", i + 1), 32'(req_ready), 32'h0);
      end
      chk("stall_ptr", 32'(dut.ptr_q), 32'h1);
      cdb_stall = 1'b0;
      #1;
      chk("unstall_ready", 32'(req_ready), 32'h1);
      tick();
      chk("unstall_tag", 32'(cdb_tag), 32'h7);
      chk("unstall_data", cdb_data, 32'h55);
      chk("unstall_src", 32'(cdb_src), 32'h0);

      // Flush during stall
      req_valid = 3'b010;
      set_req(1, 3'd4, 32'hABC);
      cdb_stall = 1'b1;
      flush = 1'b1;
      #1;
      chk("flush_ready", 32'(req_ready), 32'h0);
      tick();
      chk("flush_valid", 32'(cdb_valid), 32'h0);
      chk("flush_ptr", 32'(dut.ptr_q), 32'h1);
      flush = 1'b0;
      #1;
      chk("postflush_ready", 32'(req_ready), 32'h2);
      tick();
      chk("postflush_valid", 32'(cdb_valid), 32'h1);
      chk("postflush_tag", 32'(cdb_tag), 32'h4);
      chk("postflush_src", 32'(cdb_src), 32'h1);
      chk("postflush_ptr", 32'(dut.ptr_q), 32'h2);
      cdb_stall = 1'b0;

      // Idle after a broadcast
      req_valid = 3'b000;
      #1;
      chk("idle_ready", 32'(req_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("idle_valid%0d", i), 32'(cdb_valid), 32'h0);
         chk($sformatf("idle_ptr%0d", i), 32'(dut.ptr_q), 32'h2);
      end

      // Reset while stalled with a valid broadcast
      req_valid = 3'b001;
      tick();
      chk("rst2_load_valid", 32'(cdb_valid), 32'h1);
      cdb_stall = 1'b1;
      rst = 1'b0;
      #1;
      chk("rst2_ready", 32'(req_ready), 32'h0);
      tick();
      chk("rst2_valid", 32'(cdb_valid), 32'h0);
      chk("rst2_tag", 32'(cdb_tag), 32'h0);
      chk("rst2_src", 32'(cdb_src), 32'h0);
      chk("rst2_ptr", 32'(dut.ptr_q), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the out-of-order core's result producers: ALU reservation station, branch reservation station and load/store queue. Each cycle it grants at most one ready result and drives it onto a registered CDB output. The ROB and all reservation stations snoop that output to wake dependents and mark entries ready for commit. It also honours ROB back-pressure and pipeline flush on branch mispredict.

## Interface
- NUM_REQ, 3, number of requesters; index 0 = ALU RS, 1 = branch RS, 2 = LSQ
- TAG_W, 3, ROB index width (ROB size 8)
- WIDTH, 32, result data width
- SRC_W, $clog2(NUM_REQ), width of source-id output
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-low
- req_valid[NUM_REQ]  in  1 each  requester holds a finished result
- req_tag[NUM_REQ]  in  TAG_W each  destination ROB index
- req_data[NUM_REQ]  in  WIDTH each  result value
- req_ready[NUM_REQ]  out  1 each  grant; at most one high per cycle
- flush  in  1  mispredict flush from ROB
- cdb_stall  in  1  ROB cannot accept a broadcast this cycle
- cdb_valid  out  1  CDB carries a result
- cdb_tag  out  TAG_W  broadcast ROB index
- cdb_data  out  WIDTH  broadcast value
- cdb_src  out  SRC_W  requester index that produced the broadcast

## Operation
- State: output register {cdb_valid, cdb_tag, cdb_data, cdb_src} and rotating priority pointer ptr (SRC_W bits, range 0..NUM_REQ-1).
- Output register is free when cdb_valid==0 or cdb_stall==0.
- Grant condition: rst==1, flush==0, register free, at least one req_valid. Winner is the first valid index scanning ptr, ptr+1, … with wrap modulo NUM_REQ.
- req_ready[winner] is asserted combinationally in the grant cycle. It depends only on req_valid, ptr, cdb_valid, cdb_stall, flush and rst, never on req_tag or req_data.
- On grant at the clock edge, the register loads {1, req_tag[w], req_data[w], w}. ptr becomes (w+1) mod NUM_REQ, with explicit wrap because NUM_REQ need not be a power of two.
- If the register is free and there is no grant, cdb_valid <= 0. Tag, data and src hold their old values, which are don't-care.
- Stall (cdb_valid==1 and cdb_stall==1, no flush): all outputs and ptr hold, all req_ready stay 0.
- Flush overrides stall and grant: no req_ready that cycle, cdb_valid <= 0, ptr unchanged. Discarding requester state is the requesters' own job.
- Requester contract: once req_valid rises, it stays high with stable tag and data until req_ready. The arbiter never grants an invalid requester.
- Reset (rst==0 at an edge): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, ptr=0. req_ready forced 0 while rst==0. Reset mid-stall or mid-flush behaves identically.

## Timing
- Latency: grant cycle N → cdb_valid/tag/data/src visible in cycle N+1.
- Throughput: one broadcast per cycle with no bubbles when cdb_stall==0.
- A stalled broadcast stays on the bus until the first cycle with cdb_stall==0. In that same cycle a new winner may be granted, so it appears back-to-back.
- Fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ grants. No starvation beyond NUM_REQ-1 grants to others.
- The ptr update uses only the granted index. Cycles without a grant do not advance ptr.

## Structure
- Add `cdb_t` (valid, tag, data, src) and `CDB_NUM_REQ` / index constants (CDB_ALU=0, CDB_BR=1, CDB_LSQ=2) to `rv32i_types`. RS, LSQ and ROB consume the same struct.
- One sub-module: `rr_arbiter`, a parameterized combinational rotate-priority-select. Inputs: request vector, ptr, enable. Outputs: one-hot grant plus encoded index.
- The top module holds ptr, the output register, the free/stall/flush logic and the payload mux.

## Test plan
- Reset: hold rst=0 for 3 cycles with all req_valid=1 → all req_ready=0, cdb_valid=0. First cycle after release → req_ready[0]=1; next cycle cdb_src=0.
- Full contention: all valid with tags 1/2/3, ptr=0, no stall → grants 0,1,2,0,1 on consecutive cycles. cdb_tag sequence 1,2,3,1,2, one cycle delayed.
- Wrap: only req2 valid (tag 6, data 0x1234) with ptr=0 → req_ready[2] same cycle. Next cycle: cdb_tag=6, cdb_data=0x1234, ptr=0.
- Stall: cdb_valid=1, tag 5, data 0xDEADBEEF; cdb_stall=1 for 3 cycles with req0 valid → outputs unchanged, req_ready all 0. Stall drops → req_ready[0]=1 that cycle, req0 payload on bus the next cycle.
- Flush during stall: cdb_valid=1, cdb_stall=1, flush=1, req1 valid → no ready, cdb_valid=0 next cycle, ptr unchanged. With flush=0 the following cycle, req1 is granted.
- Idle: no req_valid for 4 cycles after a broadcast → cdb_valid=0 from the second cycle, ptr unchanged.
